cbi_audio_fifo_bank: RTL and testbench

- Parametrised multi-channel sample buffer between the bus-side register file and the codec serial interface of the CBI audio core.
- Each channel has one RX FIFO (codec -> host) and one TX FIFO (host -> codec).
- Supersedes the fixed 2-channel, 16-entry, 32-bit FIFOs with the following:
  - full-depth pointers;
  - guarded push/pop;
  - sticky overflow/underflow flags;
  - level counters, watermarks and per-channel flush.

---
 rtl/cbi_audio_fifo_bank.sv | 153 +++++++++++++++
 tb/tb_cbi_audio_fifo_bank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cbi_audio_fifo_bank.sv
// Multi-channel audio sample buffer: one RX FIFO (codec->host) and one TX FIFO
// (host->codec) per channel, with level counters, watermarks and sticky error flags.
module cbi_audio_fifo_bank #(
    parameter int NCH = 2,
    parameter int DW  = 24,
    parameter int AW  = 4,
    parameter int CW  = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NCH-1:0]        rx_en,
    input  logic [NCH-1:0]        tx_en,
    input  logic [NCH-1:0]        flush,
    input  logic [AW:0]           wm_lvl,
    input  logic [2*NCH-1:0]      flag_clr,
    input  logic                  h_wr_en,
    input  logic [CW-1:0]         h_wr_ch,
    input  logic [DW-1:0]         h_wr_data,
    output logic                  h_wr_err,
    input  logic                  h_rd_en,
    input  logic [CW-1:0]         h_rd_ch,
    output logic [DW-1:0]         h_rd_data,
    output logic                  h_rd_vld,
    output logic                  h_rd_err,
    input  logic [NCH-1:0]        c_rx_vld,
    input  logic [DW-1:0]         c_rx_data,
    input  logic [NCH-1:0]        c_tx_ack,
    output logic [NCH*DW-1:0]     c_tx_data,
    output logic [NCH*(AW+1)-1:0] rx_level,
    output logic [NCH*(AW+1)-1:0] tx_level,
    output logic [NCH-1:0]        rx_wm,
    output logic [NCH-1:0]        tx_wm,
    output logic [NCH-1:0]        ovf,
    output logic [NCH-1:0]        unf
);
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    logic [NCH-1:0] rx_pop;
    logic [NCH-1:0] tx_full;
    logic [DW-1:0]  rx_out [NCH];
    logic           wr_ch_ok;
    logic           wr_full_sel;
    logic           rd_ok;
    logic [DW-1:0]  rd_sample;

    assign wr_ch_ok = ({1'b0, h_wr_ch} < (CW+1)'(NCH));

    always_comb begin
        wr_full_sel = 1'b0;
        rd_sample   = '0;
        for (int c = 0; c < NCH; c++) begin
            if (h_wr_ch == CW'(c)) wr_full_sel = tx_full[c];
            if (h_rd_ch == CW'(c)) rd_sample = rx_out[c];
        end
    end

    // Full test uses the pre-cycle level, so a same-cycle codec pop does not rescue a write.
    assign h_wr_err = h_wr_en & (~wr_ch_ok | wr_full_sel);
    assign rd_ok    = |rx_pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_rd_data <= '0;
            h_rd_vld  <= 1'b0;
            h_rd_err  <= 1'b0;
        end else begin
            h_rd_vld <= rd_ok;
            h_rd_err <= h_rd_en & ~rd_ok;
            if (rd_ok) h_rd_data <= rd_sample;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [PW-1:0] rx_head_reg, rx_tail_reg, tx_head_reg, tx_tail_reg;
        logic [PW-1:0] rx_lvl, tx_lvl;
        logic [DW-1:0] rx_mem [DEPTH];
        logic [DW-1:0] tx_mem [DEPTH];
        logic [DW-1:0] tx_data_reg;
        logic          ovf_reg, unf_reg;
        logic          rx_full, rx_empty, tx_empty;
        logic          rx_req, rx_push, ovf_set;
        logic          tx_req, tx_pop, tx_push, unf_set;

        assign rx_lvl      = rx_head_reg - rx_tail_reg;
        assign tx_lvl      = tx_head_reg - tx_tail_reg;
        assign rx_full     = (rx_lvl == FULL_LVL);
        assign rx_empty    = (rx_lvl == '0);
        assign tx_full[gi] = (tx_lvl == FULL_LVL);
        assign tx_empty    = (tx_lvl == '0);

        // Flush masks every operation on this channel, including flag setting.
        assign rx_pop[gi] = h_rd_en && (h_rd_ch == CW'(gi)) && !rx_empty && !flush[gi];
        assign rx_req     = c_rx_vld[gi] && rx_en[gi] && !flush[gi];
        assign rx_push    = rx_req && (!rx_full || rx_pop[gi]);
        assign ovf_set    = rx_req && rx_full && !rx_pop[gi];

        assign tx_push = h_wr_en && (h_wr_ch == CW'(gi)) && !tx_full[gi] && !flush[gi];
        assign tx_req  = c_tx_ack[gi] && tx_en[gi] && !flush[gi];
        assign tx_pop  = tx_req && !tx_empty;
        assign unf_set = tx_req && tx_empty;

        assign rx_out[gi] = rx_mem[rx_tail_reg[AW-1:0]];

        always_ff @(posedge clk) begin
            if (rx_push) rx_mem[rx_head_reg[AW-1:0]] <= c_rx_data;
            if (tx_push) tx_mem[tx_head_reg[AW-1:0]] <= h_wr_data;
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rx_head_reg <= '0;
                rx_tail_reg <= '0;
                tx_head_reg <= '0;
                tx_tail_reg <= '0;
                tx_data_reg <= '0;
                ovf_reg     <= 1'b0;
                unf_reg     <= 1'b0;
            end else begin
                if (flush[gi]) begin
                    rx_head_reg <= '0;
                    rx_tail_reg <= '0;
                    tx_head_reg <= '0;
                    tx_tail_reg <= '0;
                    tx_data_reg <= '0;
                end else begin
                    if (rx_push)    rx_head_reg <= rx_head_reg + 1'b1;
                    if (rx_pop[gi]) rx_tail_reg <= rx_tail_reg + 1'b1;
                    if (tx_push)    tx_head_reg <= tx_head_reg + 1'b1;
                    if (tx_pop) begin
                        tx_tail_reg <= tx_tail_reg + 1'b1;
                        tx_data_reg <= tx_mem[tx_tail_reg[AW-1:0]];
                    end else if (unf_set) begin
                        tx_data_reg <= '0;
                    end
                end
                // A set in the same cycle as a clear keeps the flag high.
                ovf_reg <= ovf_set | (ovf_reg & ~flag_clr[2*gi]);
                unf_reg <= unf_set | (unf_reg & ~flag_clr[2*gi+1]);
            end
        end

        assign rx_level[gi*PW +: PW]  = rx_lvl;
        assign tx_level[gi*PW +: PW]  = tx_lvl;
        assign rx_wm[gi]              = (rx_lvl >= wm_lvl) && (wm_lvl != '0);
        assign tx_wm[gi]              = (tx_lvl <= wm_lvl);
        assign c_tx_data[gi*DW +: DW] = tx_data_reg;
        assign ovf[gi]                = ovf_reg;
        assign unf[gi]                = unf_reg;
    end

endmodule

// File: tb/tb_cbi_audio_fifo_bank.sv
// Scoreboard bench for cbi_audio_fifo_bank: queues of expected samples are filled
// as stimulus is driven and drained as the DUT presents read / TX data.
module tb_cbi_audio_fifo_bank;
    localparam int NCH = 2;
    localparam int DW  = 24;
    localparam int AW  = 4;
    localparam int CW  = 3;
    localparam int PW  = AW + 1;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NCH-1:0]      rx_en, tx_en, flush;
    logic [AW:0]         wm_lvl;
    logic [2*NCH-1:0]    flag_clr;
    logic                h_wr_en;
    logic [CW-1:0]       h_wr_ch;
    logic [DW-1:0]       h_wr_data;
    logic                h_wr_err;
    logic                h_rd_en;
    logic [CW-1:0]       h_rd_ch;
    logic [DW-1:0]       h_rd_data;
    logic                h_rd_vld, h_rd_err;
    logic [NCH-1:0]      c_rx_vld;
    logic [DW-1:0]       c_rx_data;
    logic [NCH-1:0]      c_tx_ack;
    logic [NCH*DW-1:0]   c_tx_data;
    logic [NCH*PW-1:0]   rx_level, tx_level;
    logic [NCH-1:0]      rx_wm, tx_wm, ovf, unf;

    cbi_audio_fifo_bank #(.NCH(NCH), .DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rstn(rstn), .rx_en(rx_en), .tx_en(tx_en), .flush(flush),
        .wm_lvl(wm_lvl), .flag_clr(flag_clr),
        .h_wr_en(h_wr_en), .h_wr_ch(h_wr_ch), .h_wr_data(h_wr_data), .h_wr_err(h_wr_err),
        .h_rd_en(h_rd_en), .h_rd_ch(h_rd_ch), .h_rd_data(h_rd_data),
        .h_rd_vld(h_rd_vld), .h_rd_err(h_rd_err),
        .c_rx_vld(c_rx_vld), .c_rx_data(c_rx_data), .c_tx_ack(c_tx_ack), .c_tx_data(c_tx_data),
        .rx_level(rx_level), .tx_level(tx_level), .rx_wm(rx_wm), .tx_wm(tx_wm),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] rxq [$];
    logic [DW-1:0] txq [$];
    logic [DW-1:0] exp_d;
    logic [DW-1:0] last_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("  ok %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] rxl(input int c);
        return rx_level[c*PW +: PW];
    endfunction

    function automatic logic [PW-1:0] txl(input int c);
        return tx_level[c*PW +: PW];
    endfunction

    function automatic logic [DW-1:0] txd(input int c);
        return c_tx_data[c*DW +: DW];
    endfunction

    task automatic rx_push0(input logic [DW-1:0] d, input bit accept);
        c_rx_vld  = 2'b01;
        c_rx_data = d;
        tick();
        c_rx_vld  = '0;
        if (accept) rxq.push_back(d);
    endtask

    task automatic tx_write(input int ch, input logic [DW-1:0] d);
        h_wr_en   = 1'b1;
        h_wr_ch   = CW'(ch);
        h_wr_data = d;
        tick();
        h_wr_en   = 1'b0;
    endtask

    task automatic read0_ok();
        h_rd_en = 1'b1;
        h_rd_ch = '0;
        tick();
        h_rd_en = 1'b0;
        exp_d   = rxq.pop_front();
        check("rd_vld", 32'(h_rd_vld), 32'd1);
        check("rd_data", 32'(h_rd_data), 32'(exp_d));
        last_rd = exp_d;
    endtask

    initial begin
        rstn = 1'b0; rx_en = '1; tx_en = '1; flush = '0; wm_lvl = '0; flag_clr = '0;
        h_wr_en = 1'b0; h_wr_ch = '0; h_wr_data = '0; h_rd_en = 1'b0; h_rd_ch = '0;
        c_rx_vld = '0; c_rx_data = '0; c_tx_ack = '0;
        last_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_level", 32'(rx_level), 32'd0);
        check("rst_tx_level", 32'(tx_level), 32'd0);
        check("rst_rx_wm", 32'(rx_wm), 32'd0);
        check("rst_tx_wm", 32'(tx_wm), 32'b11);
        check("rst_flags", 32'({ovf, unf}), 32'd0);
        check("rst_rd", 32'({h_rd_vld, h_rd_err, h_rd_data}), 32'd0);
        check("rst_tx_data", 32'(c_tx_data[31:0]), 32'd0);
        rstn = 1'b1;
        tick();

        // TX1: fill, overfill, drain and underflow
        for (int i = 1; i <= 17; i++) begin
            h_wr_en = 1'b1; h_wr_ch = 3'd1; h_wr_data = DW'(i);
            #1;
            check("wr_err", 32'(h_wr_err), (i == 17) ? 32'd1 : 32'd0);
            if (i <= 16) txq.push_back(DW'(i));
            tick();
        end
        h_wr_en = 1'b0;
        check("tx_level1_full", 32'(txl(1)), 32'd16);
        for (int i = 1; i <= 17; i++) begin
            c_tx_ack = 2'b10;
            tick();
            c_tx_ack = '0;
            exp_d = (txq.size() > 0) ? txq.pop_front() : '0;
            check("tx_data1", 32'(txd(1)), 32'(exp_d));
            check("unf1", 32'(unf[1]), (i == 17) ? 32'd1 : 32'd0);
        end

        // RX0: overflow, drain, read error on empty
        for (int i = 0; i <= 16; i++) rx_push0(DW'(32'hA00000 + i), i < 16);
        check("rx_level0_full", 32'(rxl(0)), 32'd16);
        check("ovf0_set", 32'(ovf[0]), 32'd1);
        for (int i = 0; i < 16; i++) read0_ok();
        h_rd_en = 1'b1; h_rd_ch = '0;
        tick();
        h_rd_en = 1'b0;
        check("rd_err_empty", 32'(h_rd_err), 32'd1);
        check("rd_vld_empty", 32'(h_rd_vld), 32'd0);
        flag_clr = 4'b0001;
        tick();
        flag_clr = '0;
        check("ovf0_clr", 32'(ovf[0]), 32'd0);

        // RX0 full with simultaneous push and pop
        for (int i = 0; i < 16; i++) rx_push0(DW'(32'hB00000 + i), 1'b1);
        c_rx_vld = 2'b01; c_rx_data = DW'(32'hB00010);
        h_rd_en = 1'b1; h_rd_ch = '0;
        exp_d = rxq.pop_front();
        rxq.push_back(DW'(32'hB00010));
        tick();
        c_rx_vld = '0; h_rd_en = 1'b0;
        check("fullrw_vld", 32'(h_rd_vld), 32'd1);
        check("fullrw_data", 32'(h_rd_data), 32'(exp_d));
        check("fullrw_ovf", 32'(ovf[0]), 32'd0);
        check("fullrw_level", 32'(rxl(0)), 32'd16);
        for (int i = 0; i < 16; i++) read0_ok();

        // Watermarks
        wm_lvl = 5'd4;
        for (int i = 1; i <= 4; i++) begin
            rx_push0(DW'(32'hC00000 + i), 1'b1);
            check("rx_wm0", 32'(rx_wm[0]), (i >= 4) ? 32'd1 : 32'd0);
        end
        for (int i = 1; i <= 5; i++) begin
            tx_write(0, DW'(32'hC10000 + i));
            check("tx_wm0", 32'(tx_wm[0]), (i <= 4) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++) read0_ok();
        flush = 2'b01;
        tick();
        flush = '0;
        check("flush0_tx_level", 32'(txl(0)), 32'd0);

        // Flush TX1 against a concurrent write
        for (int i = 1; i <= 8; i++) begin
            tx_write(1, DW'(32'hD00000 + i));
            txq.push_back(DW'(32'hD00000 + i));
        end
        c_tx_ack = 2'b10;
        tick();
        c_tx_ack = '0;
        exp_d = txq.pop_front();
        check("pre_flush_tx1", 32'(txd(1)), 32'(exp_d));
        flush = 2'b10; h_wr_en = 1'b1; h_wr_ch = 3'd1; h_wr_data = DW'(32'hEEEEEE);
        tick();
        flush = '0; h_wr_en = 1'b0;
        txq.delete();
        check("flush1_level", 32'(txl(1)), 32'd0);
        check("flush1_data", 32'(txd(1)), 32'd0);
        check("flush1_unf", 32'(unf[1]), 32'd1);
        c_tx_ack = 2'b10; flag_clr = 4'b1000;
        tick();
        c_tx_ack = '0; flag_clr = '0;
        check("unf1_set_beats_clr", 32'(unf[1]), 32'd1);
        flag_clr = 4'b1000;
        tick();
        flag_clr = '0;
        check("unf1_clr", 32'(unf[1]), 32'd0);

        // Out-of-range channels
        h_wr_en = 1'b1; h_wr_ch = 3'd2; h_wr_data = DW'(32'h123);
        h_rd_en = 1'b1; h_rd_ch = 3'd3;
        #1;
        check("wr_err_badch", 32'(h_wr_err), 32'd1);
        tick();
        h_wr_en = 1'b0; h_rd_en = 1'b0;
        check("rd_err_badch", 32'(h_rd_err), 32'd1);
        check("rd_vld_badch", 32'(h_rd_vld), 32'd0);
        check("rd_data_hold", 32'(h_rd_data), 32'(last_rd));
        check("badch_levels", 32'({rx_level, tx_level}), 32'd0);

        // Asynchronous reset mid-burst
        c_tx_ack = 2'b01;
        tick();
        c_tx_ack = '0;
        tx_write(1, DW'(32'hF00001));
        tx_write(1, DW'(32'hF00002));
        c_tx_ack = 2'b10;
        tick();
        c_tx_ack = '0;
        for (int i = 0; i < 3; i++) rx_push0(DW'(32'hF10000 + i), 1'b1);
        check("pre_rst_unf0", 32'(unf[0]), 32'd1);
        check("pre_rst_tx1", 32'(txd(1)), 32'hF00001);
        h_wr_en = 1'b1; h_wr_ch = 3'd1; h_wr_data = DW'(32'hF00003);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("arst_levels", 32'({rx_level, tx_level}), 32'd0);
        check("arst_wm", 32'({rx_wm, tx_wm}), 32'b0011);
        check("arst_flags", 32'({ovf, unf}), 32'd0);
        check("arst_rd", 32'({h_rd_vld, h_rd_err, h_rd_data}), 32'd0);
        check("arst_tx_data", 32'(c_tx_data[31:0]), 32'd0);
        check("arst_tx_data_hi", 32'(c_tx_data[NCH*DW-1:32]), 32'd0);
        h_wr_en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
